// File: rtl/id_char_gen.sv
// id_char_gen
// Builds one identifier as an ASCII character stream. The stream is a run of
// letters followed by the decimal digits of a binary number. It feeds the
// identifier recognizer, either as a stimulus source or to produce
// auto-named tokens.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset; aborts a frame with no done
//   start       frame request, looked at only while idle
//   alpha_base  first letter (A-Z or a-z)
//   alpha_len   letter count, 1..MAX_ALPHA
//   number      unsigned value emitted in decimal after the letters
//   char        current ASCII character (8'h00 when nothing is offered)
//   char_valid  char is offered to the consumer
//   char_ready  consumer takes char when char_valid && char_ready
//   busy        a frame is in progress
//   done        one-cycle pulse after the last character is taken
//   err         one-cycle pulse when a start request is rejected

module id_char_gen #(
    parameter int MAX_ALPHA = 8,
    parameter int NUM_W     = 16,
    parameter int DIGITS    = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [7:0]                     alpha_base,
    input  logic [$clog2(MAX_ALPHA+1)-1:0] alpha_len,
    input  logic [NUM_W-1:0]               number,
    output logic [7:0]                     char,
    output logic                           char_valid,
    input  logic                           char_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int AL_W  = $clog2(MAX_ALPHA + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(NUM_W + 1);
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [AL_W-1:0]  MAX_LEN  = AL_W'(MAX_ALPHA);
    localparam logic [CNT_W-1:0] CONV_END = CNT_W'(NUM_W);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        ALPHA,
        DIGIT,
        FIN
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         base_q, base_d;
    logic [AL_W-1:0]    len_q, len_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   conv_cnt_q, conv_cnt_d;
    logic [AL_W-1:0]    alpha_cnt_q, alpha_cnt_d;
    logic [DIG_W-1:0]   dig_idx_q, dig_idx_d;
    logic [7:0]         char_q, char_d;
    logic               char_valid_q, char_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [DIG_W-1:0]   msd_idx;
    logic               beat;
    logic               start_ok;

    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= "A") && (c <= "Z")) || ((c >= "a") && (c <= "z"));
    endfunction

    // Next letter with the case kept: 'z' wraps to 'a', 'Z' wraps to 'A'.
    function automatic logic [7:0] next_letter(input logic [7:0] c);
        logic [7:0] r;
        if (c == "z") begin
            r = "a";
        end else if (c == "Z") begin
            r = "A";
        end else begin
            r = c + 8'd1;
        end
        return r;
    endfunction

    function automatic logic [3:0] nibble_at(input logic [BCD_W-1:0] v,
                                             input logic [DIG_W-1:0] idx);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == DIG_W'(i)) begin
                r = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Double-dabble correction step. Each BCD nibble of 5 or more gets 3
    // added so that the following left shift carries correctly into the
    // next decimal digit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Finds the highest non-zero BCD digit. Later loop iterations win, so
    // this leading-zero skip lands on the most significant one. A value of
    // zero falls back to digit 0, so a lone '0' is still emitted.
    always_comb begin
        msd_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                msd_idx = DIG_W'(i);
            end
        end
    end

    assign beat     = char_valid_q && char_ready;
    assign start_ok = (alpha_len != '0) && (alpha_len <= MAX_LEN) && is_letter(alpha_base);

    // Next-state logic and registered output logic.
    // The character register always holds the value on offer. On each
    // accepted beat it loads the following character directly, so
    // char_valid stays high across the frame at full throughput and char
    // stays put while the consumer stalls. CONV runs NUM_W shift cycles and
    // then spends one more cycle loading the first letter. As a result the
    // first char_valid appears NUM_W+1 edges after the start edge.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        num_d        = num_q;
        bcd_d        = bcd_q;
        conv_cnt_d   = conv_cnt_q;
        alpha_cnt_d  = alpha_cnt_q;
        dig_idx_d    = dig_idx_q;
        char_d       = char_q;
        char_valid_d = char_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        base_d     = alpha_base;
                        len_d      = alpha_len;
                        num_d      = number;
                        bcd_d      = '0;
                        conv_cnt_d = '0;
                        busy_d     = 1'b1;
                        state_d    = CONV;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            CONV: begin
                if (conv_cnt_q != CONV_END) begin
                    bcd_d      = {bcd_adj[BCD_W-2:0], num_q[NUM_W-1]};
                    num_d      = {num_q[NUM_W-2:0], 1'b0};
                    conv_cnt_d = conv_cnt_q + CNT_W'(1);
                end else begin
                    char_d       = base_q;
                    char_valid_d = 1'b1;
                    alpha_cnt_d  = AL_W'(1);
                    state_d      = ALPHA;
                end
            end

            ALPHA: begin
                if (beat) begin
                    if (alpha_cnt_q == len_q) begin
                        char_d    = 8'h30 + {4'h0, nibble_at(bcd_q, msd_idx)};
                        dig_idx_d = msd_idx;
                        state_d   = DIGIT;
                    end else begin
                        char_d      = next_letter(char_q);
                        alpha_cnt_d = alpha_cnt_q + AL_W'(1);
                    end
                end
            end

            DIGIT: begin
                if (beat) begin
                    if (dig_idx_q == '0) begin
                        char_d       = 8'h00;
                        char_valid_d = 1'b0;
                        done_d       = 1'b1;
                        state_d      = FIN;
                    end else begin
                        dig_idx_d = dig_idx_q - DIG_W'(1);
                        char_d    = 8'h30 + {4'h0, nibble_at(bcd_q, dig_idx_q - DIG_W'(1))};
                    end
                end
            end

            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset drops everything at once, which
    // also abandons any frame in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            len_q        <= '0;
            num_q        <= '0;
            bcd_q        <= '0;
            conv_cnt_q   <= '0;
            alpha_cnt_q  <= '0;
            dig_idx_q    <= '0;
            char_q       <= '0;
            char_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            num_q        <= num_d;
            bcd_q        <= bcd_d;
            conv_cnt_q   <= conv_cnt_d;
            alpha_cnt_q  <= alpha_cnt_d;
            dig_idx_q    <= dig_idx_d;
            char_q       <= char_d;
            char_valid_q <= char_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign char       = char_q;
    assign char_valid = char_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_id_char_gen.sv
// Testbench for id_char_gen.
// Inputs are driven and outputs are sampled on the falling clock edge.
// Expected streams and timing are written out by hand.
module tb_id_char_gen;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  alpha_base;
   logic [3:0]  alpha_len;
   logic [15:0] number;
   logic [7:0]  char;
   logic        char_valid;
   logic        char_ready;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   id_char_gen #(
      .MAX_ALPHA(8),
      .NUM_W(16),
      .DIGITS(5)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .alpha_base(alpha_base),
      .alpha_len(alpha_len),
      .number(number),
      .char(char),
      .char_valid(char_valid),
      .char_ready(char_ready),
      .busy(busy),
      .done(done),
      .err(err)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Pulses start for one edge with the given frame inputs; returns on the
   // falling edge right after the edge that sampled start
   task automatic applyStimulus(input logic [7:0] base, input logic [3:0] len, input logic [15:0] num);
      alpha_base = base;
      alpha_len  = len;
      number     = num;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   // Follows one frame from the falling edge after the start edge.
   // mode 0: ready always high
   // mode 1: ready low for three cycles on the second character, then random
   // mode 2: ready high, with extra start pulses during CONV and ALPHA
   task automatic runFrame(input string exp, input int mode);
      int         cyc;
      int         beats;
      int         first;
      int         stallCnt;
      bit         stalled;
      bit         finished;
      bit         expectDone;
      logic [7:0] held;
      cyc        = 0;
      beats      = 0;
      first      = -1;
      stallCnt   = 0;
      stalled    = 1'b0;
      finished   = 1'b0;
      expectDone = 1'b0;
      held       = 8'h00;
      while (!finished && cyc < 400) begin
         if (mode == 1) begin
            if (beats == 1 && stallCnt < 3) begin
               char_ready = 1'b0;
               stallCnt++;
            end else if (beats >= 2) begin
               char_ready = 1'($urandom_range(0, 1));
            end else begin
               char_ready = 1'b1;
            end
         end else begin
            char_ready = 1'b1;
         end
         if (mode == 2) begin
            if (cyc == 5) begin
               start      = 1'b1;
               alpha_base = "c";
               alpha_len  = 4'd1;
               number     = 16'd9;
            end else if (cyc == 18) begin
               start = 1'b1;
            end else begin
               start = 1'b0;
            end
         end
         if (cyc == 1) checkOutput("busy_conv", {31'd0, busy}, 32'd1);
         checkOutput("no_err", {31'd0, err}, 32'd0);
         if (expectDone) begin
            checkOutput("done", {31'd0, done}, 32'd1);
            checkOutput("valid_after", {31'd0, char_valid}, 32'd0);
            checkOutput("char_after", {24'd0, char}, 32'd0);
            finished = 1'b1;
         end else begin
            checkOutput("no_early_done", {31'd0, done}, 32'd0);
            if (stalled) begin
               checkOutput("hold_char", {24'd0, char}, {24'd0, held});
               checkOutput("hold_valid", {31'd0, char_valid}, 32'd1);
            end
            if (first < 0 && char_valid) begin
               first = cyc;
               checkOutput("latency", 32'(cyc), 32'd17);
            end
            if (first >= 0) checkOutput("valid_cont", {31'd0, char_valid}, 32'd1);
            if (char_valid && char_ready) begin
               checkOutput("char", {24'd0, char}, 32'(exp[beats]));
               beats++;
               if (beats == exp.len()) expectDone = 1'b1;
            end
            stalled = char_valid && !char_ready;
            held    = char;
         end
         if (!finished) begin
            @(negedge clk);
            cyc++;
         end
      end
      start      = 1'b0;
      char_ready = 1'b1;
      checkOutput("frame_done", {31'd0, finished}, 32'd1);
      checkOutput("beats", 32'(beats), 32'(exp.len()));
      @(negedge clk);
      checkOutput("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   logic [7:0] badBase [3];
   logic [3:0] badLen  [3];

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      alpha_base = 8'h00;
      alpha_len  = 4'd0;
      number     = 16'd0;
      char_ready = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] reset state");
      checkOutput("rst_char", {24'd0, char}, 32'd0);
      checkOutput("rst_valid", {31'd0, char_valid}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_err", {31'd0, err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] xyza1203");
      applyStimulus("x", 4'd4, 16'd1203);
      runFrame("xyza1203", 0);

      $display("[TB] A0 then ZAB65535");
      applyStimulus("A", 4'd1, 16'd0);
      runFrame("A0", 0);
      applyStimulus("Z", 4'd3, 16'd65535);
      runFrame("ZAB65535", 0);

      $display("[TB] rejected starts");
      badBase[0] = "a"; badLen[0] = 4'd0;
      badBase[1] = "a"; badLen[1] = 4'd9;
      badBase[2] = "5"; badLen[2] = 4'd3;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(badBase[i], badLen[i], 16'd100);
         checkOutput("err_pulse", {31'd0, err}, 32'd1);
         checkOutput("err_busy", {31'd0, busy}, 32'd0);
         checkOutput("err_valid", {31'd0, char_valid}, 32'd0);
         @(negedge clk);
         checkOutput("err_once", {31'd0, err}, 32'd0);
         checkOutput("err_idle", {31'd0, busy}, 32'd0);
      end

      $display("[TB] backpressure ab42");
      applyStimulus("a", 4'd2, 16'd42);
      runFrame("ab42", 1);

      $display("[TB] start ignored while busy");
      applyStimulus("m", 4'd4, 16'd77);
      runFrame("mnop77", 2);

      $display("[TB] reset during digits");
      char_ready = 1'b1;
      applyStimulus("h", 4'd2, 16'd345);
      repeat (20) @(negedge clk);
      checkOutput("pre_rst_char", {24'd0, char}, 32'h34);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_char", {24'd0, char}, 32'd0);
      checkOutput("arst_valid", {31'd0, char_valid}, 32'd0);
      checkOutput("arst_busy", {31'd0, busy}, 32'd0);
      checkOutput("arst_done", {31'd0, done}, 32'd0);
      checkOutput("arst_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("arst_no_done", {31'd0, done}, 32'd0);
         checkOutput("arst_no_valid", {31'd0, char_valid}, 32'd0);
      end
      applyStimulus("q", 4'd1, 16'd7);
      runFrame("q7", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case the stimulus itself gets stuck
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
